cr16_mem_arbiter: RTL

Two-requester arbiter that shares the single read/write port A of the CR16 BRAM between the CR16 core (requester 0) and an external agent such as a program loader or debug reader (requester 1). It performs round-robin arbitration with an optional bus lock for multi-access sequences. It drives the BRAM command combinationally from the winning requester and routes the synchronous-read data back to the owner one cycle later. It sits between `cr16`/loader and `bram`, and replaces a hard-wired core-to-port-A connection.

---
 rtl/cr16_mem_arbiter.sv | 182 ++++++++++++++++++
 1 files changed

// File: rtl/cr16_mem_arbiter.sv
// cr16_mem_arbiter
// Shares BRAM port A between the CR16 core (requester 0) and an external
// agent (requester 1). Round-robin between the two, with an optional bus
// lock that keeps ownership across a multi-access sequence. The BRAM command
// is driven combinationally from the winner. Read data comes back one cycle
// later, and a registered tag marks which requester owns it.
module cr16_mem_arbiter #(
   parameter int P_DATA_WIDTH    = 16,
   parameter int P_ADDRESS_WIDTH = 16
) (
   input  logic                       I_CLK,
   input  logic                       I_NRESET,
   input  logic                       I_REQ_0,
   input  logic                       I_WE_0,
   input  logic [P_ADDRESS_WIDTH-1:0] I_ADDR_0,
   input  logic [P_DATA_WIDTH-1:0]    I_WDATA_0,
   input  logic                       I_LOCK_0,
   input  logic                       I_REQ_1,
   input  logic                       I_WE_1,
   input  logic [P_ADDRESS_WIDTH-1:0] I_ADDR_1,
   input  logic [P_DATA_WIDTH-1:0]    I_WDATA_1,
   input  logic                       I_LOCK_1,
   output logic                       O_GNT_0,
   output logic                       O_GNT_1,
   output logic                       O_RVALID_0,
   output logic                       O_RVALID_1,
   output logic [P_DATA_WIDTH-1:0]    O_RDATA_0,
   output logic [P_DATA_WIDTH-1:0]    O_RDATA_1,
   output logic [P_ADDRESS_WIDTH-1:0] O_MEM_ADDRESS,
   output logic [P_DATA_WIDTH-1:0]    O_MEM_DATA,
   output logic                       O_MEM_WRITE_ENABLE,
   input  logic [P_DATA_WIDTH-1:0]    I_MEM_DATA
);

   typedef enum logic [1:0] {
      IDLE     = 2'd0,
      LOCKED_0 = 2'd1,
      LOCKED_1 = 2'd2
   } state_t;

   state_t     state;
   state_t     next_state;
   logic       last;
   logic [3:0] idle_cnt;
   logic       rtag_0;
   logic       rtag_1;
   logic       req_0;
   logic       req_1;
   logic       gnt_0;
   logic       gnt_1;
   logic       owner_idle;

   // Requests are masked during reset so no grant or BRAM write escapes while I_NRESET is low
   always_comb begin
      req_0 = I_REQ_0 & I_NRESET;
      req_1 = I_REQ_1 & I_NRESET;
   end

   // State register
   always_ff @(posedge I_CLK or negedge I_NRESET) begin
      if (!I_NRESET) begin
         state <= IDLE;
      end else begin
         state <= next_state;
      end
   end

   // Winner selection and BRAM command mux; a locked owner excludes the other requester entirely
   always_comb begin
      gnt_0              = 1'b0;
      gnt_1              = 1'b0;
      O_MEM_ADDRESS      = '0;
      O_MEM_DATA         = '0;
      O_MEM_WRITE_ENABLE = 1'b0;
      case (state)
         IDLE: begin
            if (req_0 && req_1) begin
               gnt_0 = last;
               gnt_1 = ~last;
            end else begin
               gnt_0 = req_0;
               gnt_1 = req_1;
            end
         end
         LOCKED_0: gnt_0 = req_0;
         LOCKED_1: gnt_1 = req_1;
         default: begin
            gnt_0 = 1'b0;
            gnt_1 = 1'b0;
         end
      endcase
      if (gnt_0) begin
         O_MEM_ADDRESS      = I_ADDR_0;
         O_MEM_DATA         = I_WDATA_0;
         O_MEM_WRITE_ENABLE = I_WE_0;
      end else if (gnt_1) begin
         O_MEM_ADDRESS      = I_ADDR_1;
         O_MEM_DATA         = I_WDATA_1;
         O_MEM_WRITE_ENABLE = I_WE_1;
      end
   end

   // The lock owner being absent is what the abandonment timer counts
   always_comb begin
      owner_idle = 1'b0;
      if (state == LOCKED_0) owner_idle = ~req_0;
      if (state == LOCKED_1) owner_idle = ~req_1;
   end

   // Next state: take or release a lock on a grant, or drop it after sixteen idle cycles
   always_comb begin
      next_state = state;
      case (state)
         IDLE: begin
            if (gnt_0 && I_LOCK_0) begin
               next_state = LOCKED_0;
            end else if (gnt_1 && I_LOCK_1) begin
               next_state = LOCKED_1;
            end
         end
         LOCKED_0: begin
            if (gnt_0 && !I_LOCK_0) begin
               next_state = IDLE;
            end else if (owner_idle && idle_cnt == 4'd15) begin
               next_state = IDLE;
            end
         end
         LOCKED_1: begin
            if (gnt_1 && !I_LOCK_1) begin
               next_state = IDLE;
            end else if (owner_idle && idle_cnt == 4'd15) begin
               next_state = IDLE;
            end
         end
         default: next_state = IDLE;
      endcase
   end

   // Round-robin memory: remembers who was granted last so the other side wins the next tie
   always_ff @(posedge I_CLK or negedge I_NRESET) begin
      if (!I_NRESET) begin
         last <= 1'b1;
      end else if (gnt_0) begin
         last <= 1'b0;
      end else if (gnt_1) begin
         last <= 1'b1;
      end
   end

   // Idle counter runs only while a lock is held and its owner is absent; any grant or state change clears it
   always_ff @(posedge I_CLK or negedge I_NRESET) begin
      if (!I_NRESET) begin
         idle_cnt <= 4'd0;
      end else if (gnt_0 || gnt_1 || next_state != state || !owner_idle) begin
         idle_cnt <= 4'd0;
      end else begin
         idle_cnt <= idle_cnt + 4'd1;
      end
   end

   // Return tag marks which requester owns the BRAM read data arriving next cycle
   always_ff @(posedge I_CLK or negedge I_NRESET) begin
      if (!I_NRESET) begin
         rtag_0 <= 1'b0;
         rtag_1 <= 1'b0;
      end else begin
         rtag_0 <= gnt_0 & ~I_WE_0;
         rtag_1 <= gnt_1 & ~I_WE_1;
      end
   end

   // Output drive: grants, read-valid strobes and read data shared by both requesters
   always_comb begin
      O_GNT_0    = gnt_0;
      O_GNT_1    = gnt_1;
      O_RVALID_0 = rtag_0;
      O_RVALID_1 = rtag_1;
      O_RDATA_0  = I_MEM_DATA;
      O_RDATA_1  = I_MEM_DATA;
   end

endmodule
